// File: rtl/rf_arb_pkg.sv
// Shared encodings and small helpers for the register-file read-port arbiter.
// Requester codes are kept in 0..2 because the address mux output is undefined for code 3.
package rf_arb_pkg;

  localparam int AW_DEFAULT = 5;

  localparam logic [1:0] SEL_R0 = 2'd0;
  localparam logic [1:0] SEL_R1 = 2'd1;
  localparam logic [1:0] SEL_R2 = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // (a + b) mod 3 for requester codes; an out-of-range a folds back into 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] sel_onehot(input logic [1:0] s);
    case (s)
      SEL_R0:  return 3'b001;
      SEL_R1:  return 3'b010;
      SEL_R2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker.
// The search starts at ptr and walks ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3
  import rf_arb_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx,
  output logic [2:0] onehot
);

  logic [1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = SEL_R0;
    cand = SEL_R0;
    // Walk the order backwards so the candidate closest to ptr is written last and wins.
    for (int k = 2; k >= 0; k--) begin
      cand = mod3_add(ptr, 2'(k));
      if (eligible[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot = sel_onehot(idx) & {3{any}};
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port between three requesters.
// It presents a registered address/select with a valid flag and pulses a one-cycle grant on acceptance.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic          port_ready,
  output logic          port_valid,
  output logic [AW-1:0] port_addr,
  output logic [1:0]    sel,
  output logic [2:0]    gnt
);

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [2:0]    sel_oh;
  logic [2:0]    eligible;
  logic          fire;
  logic          pick_any;
  logic [1:0]    pick_idx;
  logic [2:0]    pick_oh;
  logic [AW-1:0] pick_addr;
  logic [AW-1:0] addr_arr [3];
  logic [AW-1:0] addr_masked [3];

  assign sel_oh   = sel_onehot(sel_q);
  assign fire     = (state_q == ST_ISSUE) && port_ready;
  // The requester being served this cycle is excluded so it cannot win twice in a row.
  assign eligible = (state_q == ST_ISSUE) ? (req & ~sel_oh) : req;

  rr_pick3 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (pick_any),
    .idx      (pick_idx),
    .onehot   (pick_oh)
  );

  assign addr_arr[0] = addr0;
  assign addr_arr[1] = addr1;
  assign addr_arr[2] = addr2;

  // Address capture mux in AND-OR form, steered by the picker's winner.
  for (genvar gi = 0; gi < 3; gi++) begin : g_addr_mux
    assign addr_masked[gi] = addr_arr[gi] & {AW{pick_oh[gi]}};
  end
  assign pick_addr = addr_masked[0] | addr_masked[1] | addr_masked[2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ISSUE;
          sel_d   = pick_idx;
          addr_d  = pick_addr;
        end
      end
      ST_ISSUE: begin
        if (port_ready) begin
          ptr_d = mod3_add(sel_q, 2'd1);
          if (pick_any) begin
            sel_d  = pick_idx;
            addr_d = pick_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_R0;
      sel_q   <= SEL_R0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
    end
  end

  // A grant in a reset cycle would acknowledge a request that reset discards.
  assign gnt        = (fire && !reset) ? sel_oh : 3'b000;
  assign port_valid = (state_q == ST_ISSUE);
  assign sel        = sel_q;
  assign port_addr  = addr_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: directed scenarios plus protocol-respecting random traffic,
// every cycle compared against a request-level reference model.
module tb_rf_port_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [4:0] addr0, addr1, addr2;
  logic       port_ready;
  logic       port_valid;
  logic [4:0] port_addr;
  logic [1:0] sel;
  logic [2:0] gnt;

  rf_port_arbiter #(.AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .addr0      (addr0),
    .addr1      (addr1),
    .addr2      (addr2),
    .port_ready (port_ready),
    .port_valid (port_valid),
    .port_addr  (port_addr),
    .sel        (sel),
    .gnt        (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the request currently presented to the port, if any, plus the rotation start.
  bit         m_busy = 1'b0;
  int         m_who  = 0;
  logic [4:0] m_addr = 5'd0;
  int         m_ptr  = 0;

  logic       obs_valid;
  logic [1:0] obs_sel;
  logic [4:0] obs_addr;
  logic [2:0] obs_gnt;
  logic [2:0] exp_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] elig, input int start);
    for (int k = 0; k < 3; k++) begin
      if (elig[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs at the falling edge, sample shortly after, advance the model.
  task automatic cycle(input bit rst, input logic [2:0] r, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2, input bit rdy);
    logic [2:0] elig;
    int         w;
    bit         served;
    reset = rst; req = r; addr0 = a0; addr1 = a1; addr2 = a2; port_ready = rdy;
    #1;
    obs_valid = port_valid;
    obs_sel   = sel;
    obs_addr  = port_addr;
    obs_gnt   = gnt;
    exp_gnt   = (m_busy && rdy && !rst) ? 3'(1 << m_who) : 3'b000;
    check_eq("port_valid", 32'(obs_valid), 32'(m_busy));
    check_eq("sel_not3", 32'(obs_sel != 2'd3), 32'd1);
    check_eq("gnt", 32'(obs_gnt), 32'(exp_gnt));
    check_eq("ptr", 32'(dut.ptr_q), 32'(m_ptr));
    if (m_busy) begin
      check_eq("sel", 32'(obs_sel), 32'(m_who));
      check_eq("port_addr", 32'(obs_addr), 32'(m_addr));
    end
    if (rst) begin
      m_busy = 1'b0; m_who = 0; m_addr = 5'd0; m_ptr = 0;
    end else begin
      served = m_busy && rdy;
      if (!m_busy || served) begin
        elig = r;
        if (served) elig[m_who] = 1'b0;
        w = rr_pick(elig, m_ptr);
        if (served) m_ptr = (m_who + 1) % 3;
        if (w >= 0) begin
          m_busy = 1'b1;
          m_who  = w;
          m_addr = (w == 0) ? a0 : ((w == 1) ? a1 : a2);
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    $display("cyc t=%0t rst=%0b req=%b rdy=%0b -> valid=%0b sel=%0d addr=%0d gnt=%b",
             $time, rst, r, rdy, obs_valid, obs_sel, obs_addr, obs_gnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  bit [2:0]   pend;
  logic [4:0] ra [3];
  logic [2:0] rr;
  bit         rst_r, rdy_r;
  int         gnt_count;

  initial begin
    reset = 1'b1; req = 3'b000; addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0; port_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset with all requests high, then rotation with all three requesters held.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 3'b111, 5'd3, 5'd9, 5'd27, 1'b1);
      check_eq("rst_gnt", 32'(obs_gnt), 32'd0);
      check_eq("rst_valid", 32'(obs_valid), 32'd0);
      check_eq("rst_sel", 32'(obs_sel), 32'd0);
    end
    cycle(1'b0, 3'b111, 5'd3, 5'd9, 5'd27, 1'b1);
    check_eq("rel_valid", 32'(obs_valid), 32'd0);
    begin
      logic [2:0] rot_g [4];
      logic [4:0] rot_a [4];
      rot_g[0] = 3'b001; rot_g[1] = 3'b010; rot_g[2] = 3'b100; rot_g[3] = 3'b001;
      rot_a[0] = 5'd3;   rot_a[1] = 5'd9;   rot_a[2] = 5'd27;  rot_a[3] = 5'd3;
      for (int i = 0; i < 4; i++) begin
        cycle(1'b0, 3'b111, 5'd3, 5'd9, 5'd27, 1'b1);
        if (i == 0) check_eq("first_sel", 32'(obs_sel), 32'd0);
        check_eq("rot_gnt", 32'(obs_gnt), 32'(rot_g[i]));
        check_eq("rot_addr", 32'(obs_addr), 32'(rot_a[i]));
      end
    end
    do_reset();

    // Single requester.
    cycle(1'b0, 3'b010, 5'd0, 5'd17, 5'd0, 1'b1);
    cycle(1'b0, 3'b010, 5'd0, 5'd17, 5'd0, 1'b1);
    check_eq("single_valid", 32'(obs_valid), 32'd1);
    check_eq("single_sel", 32'(obs_sel), 32'd1);
    check_eq("single_addr", 32'(obs_addr), 32'd17);
    check_eq("single_gnt", 32'(obs_gnt), 32'b010);
    cycle(1'b0, 3'b000, 5'd0, 5'd17, 5'd0, 1'b1);
    check_eq("single_drop_valid", 32'(obs_valid), 32'd0);
    check_eq("single_drop_gnt", 32'(obs_gnt), 32'd0);
    do_reset();

    // Stall: port not ready for three cycles, then exactly one grant.
    gnt_count = 0;
    cycle(1'b0, 3'b100, 5'd0, 5'd0, 5'd31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b100, 5'd0, 5'd0, 5'd31, 1'b0);
      check_eq("stall_sel", 32'(obs_sel), 32'd2);
      check_eq("stall_addr", 32'(obs_addr), 32'd31);
      check_eq("stall_gnt", 32'(obs_gnt), 32'd0);
    end
    cycle(1'b0, 3'b100, 5'd0, 5'd0, 5'd31, 1'b1);
    if (obs_gnt == 3'b100) gnt_count++;
    cycle(1'b0, 3'b000, 5'd0, 5'd0, 5'd31, 1'b1);
    if (obs_gnt != 3'b000) gnt_count++;
    check_eq("stall_gnt_once", 32'(gnt_count), 32'd1);
    do_reset();

    // Lone requester held high: grants on alternate cycles.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 1'b1);
      check_eq("lone_gnt", 32'(obs_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 3'b000, 5'd7, 5'd0, 5'd0, 1'b1);
    do_reset();

    // Reset while a request is presented to the port.
    cycle(1'b0, 3'b001, 5'd4, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 3'b001, 5'd4, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 3'b100, 5'd4, 5'd0, 5'd5, 1'b0);
    cycle(1'b0, 3'b100, 5'd4, 5'd0, 5'd5, 1'b0);
    check_eq("mid_stall_sel", 32'(obs_sel), 32'd2);
    check_eq("mid_ptr_before", 32'(dut.ptr_q), 32'd1);
    cycle(1'b1, 3'b100, 5'd4, 5'd0, 5'd5, 1'b1);
    check_eq("mid_rst_gnt", 32'(obs_gnt), 32'd0);
    cycle(1'b0, 3'b000, 5'd4, 5'd0, 5'd5, 1'b1);
    check_eq("mid_after_valid", 32'(obs_valid), 32'd0);
    check_eq("mid_after_ptr", 32'(dut.ptr_q), 32'd0);

    // Random traffic: each requester holds req/addr until granted, then re-decides.
    pend = 3'b000;
    for (int i = 0; i < 3; i++) ra[i] = 5'd0;
    for (int c = 0; c < 400; c++) begin
      rst_r = ($urandom_range(99) < 2);
      rdy_r = ($urandom_range(99) < 70);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(1) == 1)) begin
          pend[i] = 1'b1;
          ra[i]   = 5'($urandom_range(31));
        end
        rr[i] = pend[i];
      end
      cycle(rst_r, rr, ra[0], ra[1], ra[2], rdy_r);
      for (int i = 0; i < 3; i++) begin
        if (exp_gnt[i] || rst_r) pend[i] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
